// File: rtl/sccb_pkg.sv
// sccb_pkg -- shared definitions for the SCCB bit-level PHY.
//   CNT_W        : width of the quarter-period down-counter (QUARTER <= 1023)
//   OP_*         : cmd_op encodings offered by the upstream controller
//   state_e      : PHY FSM states
//   op_to_state  : maps an accepted cmd_op onto the FSM state that executes it
package sccb_pkg;

  localparam int CNT_W = 10;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BIT   = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // WRITE and READ share one state; they differ only in what SDA does.
  function automatic state_e op_to_state(input logic [1:0] op);
    state_e st;
    case (op)
      OP_START: st = ST_START;
      OP_STOP:  st = ST_STOP;
      default:  st = ST_BIT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sccb_tick.sv
// sccb_tick -- quarter-period divider for the SCCB PHY.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   load       : reload the counter with QUARTER-1 (wins over enable)
//   enable     : decrement when nonzero; low freezes the count
//   tc         : terminal count, high while the counter sits at zero
module sccb_tick
  import sccb_pkg::*;
#(
  parameter int QUARTER = 125
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(QUARTER - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/sccb_phy.sv
// sccb_phy -- SCCB (I2C-like) bit-level PHY with open-drain SCL/SDA enables.
// Executes one START / STOP / WRITE / READ bit command at a time, each as four
// quarter-period phases q0..q3. Outputs are registered so SCL/SDA enables
// change on the same edge as the FSM state.
// Optional feature: define SCCB_PHY_STRETCH_EN to honour slave clock stretching
// (quarter counter freezes in q1 while SCL is released but read back low).
// Ports:
//   clk, reset            : system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_op, cmd_bit       : command opcode and WRITE data bit
//   rsp_valid, rsp_bit    : completion pulse and sampled SDA value
//   scl_oe, sda_oe        : 1 = pull line low, 0 = release
//   scl_in, sda_in        : pad readback
//   bus_active            : high between completed START and completed STOP
module sccb_phy
  import sccb_pkg::*;
#(
  parameter int QUARTER = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_bit,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       bus_active
);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] op_q, op_d;
  logic       bit_q, bit_d;
  logic       bus_active_q, bus_active_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_bit_q, rsp_bit_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ready_en_q;

  logic accept;
  logic load;
  logic done;
  logic tc;
  logic tick_en;
  logic phase_end;
  logic stretch;

  // ready_en_q keeps cmd_ready low during reset and raises it on the first
  // edge after reset is released.
  assign cmd_ready = ready_en_q && (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef SCCB_PHY_STRETCH_EN
  // A slave holding SCL low while we release it in q1 stalls the phase.
  assign stretch = (state_q != ST_IDLE) && (phase_q == 2'd1) && !scl_oe_q && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stretch       = 1'b0;
`endif

  assign tick_en   = !stretch;
  assign phase_end = (state_q != ST_IDLE) && tc && tick_en;

  sccb_tick #(
    .QUARTER (QUARTER)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .enable (tick_en),
    .tc     (tc)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= 2'd0;
      op_q         <= OP_START;
      bit_q        <= 1'b0;
      bus_active_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_bit_q    <= 1'b0;
      scl_oe_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      op_q         <= op_d;
      bit_q        <= bit_d;
      bus_active_q <= bus_active_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_bit_q    <= rsp_bit_d;
      scl_oe_q     <= scl_oe_d;
      sda_oe_q     <= sda_oe_d;
      ready_en_q   <= 1'b1;
    end
  end

  // Next-state logic: command latch, phase sequencing, completion
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    op_d    = op_q;
    bit_d   = bit_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = op_to_state(cmd_op);
          phase_d = 2'd0;
          op_d    = cmd_op;
          bit_d   = cmd_bit;
          load    = 1'b1;
        end
      end
      default: begin
        if (phase_end) begin
          if (phase_q == 2'd3) begin
            state_d = ST_IDLE;
            phase_d = 2'd0;
            done    = 1'b1;
          end else begin
            phase_d = phase_q + 2'd1;
            load    = 1'b1;
          end
        end
      end
    endcase
  end

  // Response and bus-ownership tracking
  always_comb begin
    rsp_valid_d  = done;
    rsp_bit_d    = rsp_bit_q;
    bus_active_d = bus_active_q;
    if (accept) begin
      rsp_bit_d = 1'b0;
    end else if ((state_q == ST_BIT) && (phase_q == 2'd1) && phase_end) begin
      // Last cycle of q1: centre of the SCL-high window.
      rsp_bit_d = sda_in;
    end
    if (done && (state_q == ST_START)) begin
      bus_active_d = 1'b1;
    end else if (done && (state_q == ST_STOP)) begin
      bus_active_d = 1'b0;
    end
  end

  // Output logic, evaluated on the upcoming state/phase so the registered
  // enables line up with the state register.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = sda_oe_q;
    case (state_d)
      ST_IDLE: begin
        scl_oe_d = bus_active_d;
        sda_oe_d = sda_oe_q;
      end
      ST_START: begin
        case (phase_d)
          2'd0: begin scl_oe_d = bus_active_q; sda_oe_d = 1'b0; end
          2'd1: begin scl_oe_d = 1'b0;         sda_oe_d = 1'b0; end
          2'd2: begin scl_oe_d = 1'b0;         sda_oe_d = 1'b1; end
          default: begin scl_oe_d = 1'b1;      sda_oe_d = 1'b1; end
        endcase
      end
      ST_BIT: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
        sda_oe_d = (op_d == OP_WRITE) ? !bit_d : 1'b0;
      end
      default: begin // ST_STOP
        scl_oe_d = (phase_d == 2'd0);
        sda_oe_d = (phase_d != 2'd3);
      end
    endcase
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_bit    = rsp_bit_q;
  assign scl_oe     = scl_oe_q;
  assign sda_oe     = sda_oe_q;
  assign bus_active = bus_active_q;

endmodule

// File: tb/tb_sccb_phy.sv
// tb_sccb_phy -- directed self-checking bench for sccb_phy with QUARTER=4.
module tb_sccb_phy;
  import sccb_pkg::*;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic       cmd_bit = 1'b0;
  logic       rsp_valid;
  logic       rsp_bit;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_in;
  logic       sda_in;
  logic       bus_active;

  logic sda_low = 1'b0;   // slave (or fault) pulling SDA low
  logic scl_hold = 1'b0;  // slave stretching SCL

  // Open-drain pads with pull-ups
  assign sda_in = !sda_oe && !sda_low;
  assign scl_in = !scl_oe && !scl_hold;

  sccb_phy #(.QUARTER(Q)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_bit    (cmd_bit),
    .rsp_valid  (rsp_valid),
    .rsp_bit    (rsp_bit),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .bus_active (bus_active)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-command trace: bit k = value during cycle k after the accept edge
  logic [63:0] scl_vec, sda_vec, rdy_vec;
  int          lat;
  int          wait_cycles;
  logic        rsp_q;
  logic        rdy_at_rsp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic b, input int hold_from, input int hold_len);
    int k;
    wait_cycles = 0;
    while (!cmd_ready && wait_cycles < 200) begin
      step();
      wait_cycles++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_bit   = b;
    step();
    // Scramble inputs after acceptance; the phy must use its latched copy.
    cmd_valid = 1'b0;
    cmd_op    = op ^ 2'b11;
    cmd_bit   = !b;
    scl_vec = '0;
    sda_vec = '0;
    rdy_vec = '0;
    lat = -1;
    k = 0;
    while (lat < 0 && k < 200) begin
      if (rsp_valid) begin
        lat = k;
      end else begin
        if (k < 64) begin
          scl_vec[k] = scl_oe;
          sda_vec[k] = sda_oe;
          rdy_vec[k] = cmd_ready;
        end
        scl_hold = (k >= hold_from) && (k < hold_from + hold_len);
        step();
        k++;
      end
    end
    scl_hold   = 1'b0;
    rsp_q      = rsp_bit;
    rdy_at_rsp = cmd_ready;
    $display("cmd op=%0d bit=%0b lat=%0d rsp_bit=%0b bus_active=%0b", op, b, lat, rsp_q, bus_active);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] byte_v;
    logic [7:0] sda_line;
    logic [7:0] rsp_byte;
    logic       rdy_or;
    int         bad_lat;
    int         gap_sum;
    int         pulses;

    // ---------------- reset ----------------
    #1 reset = 1'b1;
    step();
    step();
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_bit", rsp_bit, 0);
    check("rst_bus_active", bus_active, 0);
    reset = 1'b0;
    check("rel_ready_before_edge", cmd_ready, 0);
    step();
    check("rel_ready_after_edge", cmd_ready, 1);

    // ---------------- START then STOP ----------------
    run_cmd(OP_START, 1'b0, -1, 0);
    check("start_lat", 64'(lat), 16);
    check("start_scl", scl_vec[15:0], 16'hF000);
    check("start_sda", sda_vec[15:0], 16'hFF00);
    check("start_bus_active", bus_active, 1);
    check("start_rsp_bit", rsp_q, 0);
    check("idle_scl_oe", scl_oe, 1);
    check("idle_sda_hold", sda_oe, 1);
    check("start_ready_busy", rdy_vec[15:0], 0);

    run_cmd(OP_STOP, 1'b0, -1, 0);
    check("stop_lat", 64'(lat), 16);
    check("stop_scl", scl_vec[15:0], 16'h000F);
    check("stop_sda", sda_vec[15:0], 16'h0FFF);
    check("stop_bus_active", bus_active, 0);
    check("stop_idle_lines", {scl_oe, sda_oe}, 2'b00);

    // ---------------- WRITE 1 with SDA forced low ----------------
    run_cmd(OP_START, 1'b0, -1, 0);
    sda_low = 1'b1;
    run_cmd(OP_WRITE, 1'b1, -1, 0);
    sda_low = 1'b0;
    check("wr1_lat", 64'(lat), 16);
    check("wr1_scl", scl_vec[15:0], 16'hF00F);
    check("wr1_sda", sda_vec[15:0], 16'h0000);
    check("wr1_rsp_bit", rsp_q, 0);

    // ---------------- READ: ACK then NACK ----------------
    sda_low = 1'b1;
    run_cmd(OP_READ, 1'b0, -1, 0);
    sda_low = 1'b0;
    check("rd_ack_sda", sda_vec[15:0], 16'h0000);
    check("rd_ack_rsp", rsp_q, 0);
    run_cmd(OP_READ, 1'b0, -1, 0);
    check("rd_nack_rsp", rsp_q, 1);

    // ---------------- repeated START ----------------
    run_cmd(OP_START, 1'b0, -1, 0);
    check("rstart_scl", scl_vec[15:0], 16'hF00F);
    check("rstart_sda", sda_vec[15:0], 16'hFF00);

    // ---------------- byte 0xBA, back-to-back ----------------
    byte_v   = 8'hBA;
    sda_line = '0;
    rsp_byte = '0;
    rdy_or   = 1'b0;
    bad_lat  = 0;
    gap_sum  = 0;
    for (int i = 7; i >= 0; i--) begin
      run_cmd(OP_WRITE, byte_v[i], -1, 0);
      sda_line[i] = !sda_vec[2*Q - 2];
      rsp_byte[i] = rsp_q;
      rdy_or      = rdy_or | (|rdy_vec[15:0]) | !rdy_at_rsp;
      if (lat != 16) bad_lat++;
      if (i != 7) gap_sum += wait_cycles;
    end
    check("byte_sda_line", sda_line, 8'hBA);
    check("byte_rsp_bits", rsp_byte, 8'hBA);
    check("byte_ready_pattern", rdy_or, 0);
    check("byte_bad_latency", 64'(bad_lat), 0);
    check("byte_idle_gap", 64'(gap_sum), 0);
    run_cmd(OP_STOP, 1'b0, -1, 0);
    check("byte_stop_bus", bus_active, 0);

    // ---------------- clock stretching ----------------
    run_cmd(OP_START, 1'b0, -1, 0);
    run_cmd(OP_WRITE, 1'b0, Q, 10);
`ifdef SCCB_PHY_STRETCH_EN
    check("stretch_lat", 64'(lat), 26);
`else
    check("stretch_lat", 64'(lat), 16);
`endif
    check("stretch_rsp_bit", rsp_q, 0);

    // ---------------- reset in q2 of a WRITE ----------------
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_bit   = 1'b0;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2 * Q; i++) step();
    check("q2_sda_oe_pre", sda_oe, 1);
    check("q2_bus_pre", bus_active, 1);
    reset = 1'b1;
    #1;
    check("abort_lines", {scl_oe, sda_oe}, 2'b00);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_bus_active", bus_active, 0);
    check("abort_ready", cmd_ready, 0);
    step();
    reset = 1'b0;
    step();
    check("abort_ready_after", cmd_ready, 1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) pulses++;
      step();
    end
    check("abort_no_pulse", 64'(pulses), 0);
    check("abort_bus_after", bus_active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
